varredura_display4: RTL and testbench

VARREDURA_DISPLAY4 -- requirements
Module: varredura_display4

---
 rtl/varredura_display4_pkg.sv | 40 ++++
 rtl/varredura_display4.sv | 102 ++++++++++
 tb/tb_varredura_display4.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/varredura_display4_pkg.sv
// Shared display definitions for the 4-digit multiplexed scanner and the
// downstream display7seg decoder.
//   NUM_DIGITS   : number of multiplexed digits (4)
//   BLANK_CODE   : nibble the decoder renders as an unlit digit (4'hF)
//   nibble_t     : one BCD / display code
//   digit_idx_t  : digit position 0..3
//   digit_onehot : position -> one-hot active-high digit enable
//   display_nibble : nibble to show for a digit, with optional
//                    leading-zero blanking
package varredura_display4_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] digit_idx_t;

  localparam nibble_t BLANK_CODE = 4'hF;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
    return 4'b0001 << idx;
  endfunction

  // Digit 0 is never blanked, so a value of zero still shows a single "0".
  // Digit i (i>0) is blanked when it and every digit above it are zero.
  function automatic nibble_t display_nibble(input logic [15:0] word,
                                             input digit_idx_t  idx,
                                             input logic        blank_zeros);
    logic    leading_zero;
    nibble_t raw;
    raw = word[{idx, 2'b00} +: 4];
    case (idx)
      2'd3:    leading_zero = (word[15:12] == 4'h0);
      2'd2:    leading_zero = (word[15:8]  == 8'h00);
      2'd1:    leading_zero = (word[15:4]  == 12'h000);
      default: leading_zero = 1'b0;
    endcase
    return (blank_zeros && leading_zero) ? BLANK_CODE : raw;
  endfunction

endpackage

// File: rtl/varredura_display4.sv
// Four-digit multiplexed display scanner.
// A prescaler holds each digit selected for DIVISOR clocks. Displayed data is
// double-buffered so that a new value only takes effect at a frame boundary.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   carregar    : one-cycle request to capture valores
//   valores     : four BCD nibbles, [3:0] = digit 0 ... [15:12] = digit 3
//   apaga_zeros : 1 = blank leading zeros
//   valor       : registered nibble for the display7seg decoder
//   sel         : registered one-hot active-high digit enable
//   quadro      : one-cycle pulse when the scan wraps from digit 3 to digit 0
module varredura_display4
  import varredura_display4_pkg::*;
#(
  parameter int unsigned DIVISOR = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  carregar,
  input  logic [15:0]           valores,
  input  logic                  apaga_zeros,
  output nibble_t               valor,
  output logic [NUM_DIGITS-1:0] sel,
  output logic                  quadro
);

  localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  digit_idx_t            idx_q, idx_d;
  logic [15:0]           active_q, active_d;
  logic [15:0]           pending_q, pending_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  nibble_t               valor_q, valor_d;
  logic                  quadro_q, quadro_d;
  logic                  tick;
  logic                  frame_end;

  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    frame_end = tick && (idx_q == 2'd3);

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    active_d    = active_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;

    // A capture on the boundary cycle goes straight to the display buffer;
    // otherwise it waits in the pending buffer (latest capture overwrites).
    if (carregar) begin
      if (frame_end) begin
        active_d    = valores;
        pend_flag_d = 1'b0;
      end else begin
        pending_d   = valores;
        pend_flag_d = 1'b1;
      end
    end else if (frame_end && pend_flag_q) begin
      active_d    = pending_q;
      pend_flag_d = 1'b0;
    end

    // sel/valor move together with the index and already use the buffer
    // contents that will be valid for the new digit (active_d), so a frame
    // loaded on the boundary shows its own digit 0.
    sel_d    = tick ? digit_onehot(idx_d) : sel_q;
    valor_d  = tick ? display_nibble(active_d, idx_d, apaga_zeros) : valor_q;
    quadro_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      active_q    <= 16'h0000;
      pending_q   <= 16'h0000;
      pend_flag_q <= 1'b0;
      sel_q       <= 4'b0001;
      valor_q     <= 4'h0;
      quadro_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      sel_q       <= sel_d;
      valor_q     <= valor_d;
      quadro_q    <= quadro_d;
    end
  end

  assign sel    = sel_q;
  assign valor  = valor_q;
  assign quadro = quadro_q;

endmodule

// File: tb/tb_varredura_display4.sv
// Directed bench for varredura_display4 with DIVISOR=4. Expected digit
// transitions are queued when stimulus is issued and checked as the DUT
// moves to each new digit.
module tb_varredura_display4;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        carregar;
  logic [15:0] valores;
  logic        apaga_zeros;
  logic [3:0]  valor;
  logic [3:0]  sel;
  logic        quadro;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_change = 0;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] val;
    logic       q;
  } exp_t;

  exp_t sb[$];

  varredura_display4 #(.DIVISOR(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .carregar    (carregar),
    .valores     (valores),
    .apaga_zeros (apaga_zeros),
    .valor       (valor),
    .sel         (sel),
    .quadro      (quadro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] v, input logic q);
    exp_t e;
    e.sel = s;
    e.val = v;
    e.q   = q;
    sb.push_back(e);
  endtask

  // Wait for the next digit change; optionally pulse carregar at a given
  // cycle offset within the current dwell (offset DIV-1 = the tick edge).
  task automatic run_digit(input int load_at, input logic [15:0] v);
    int         start;
    int         stray;
    logic       changed;
    logic [3:0] prev;
    exp_t       e;
    start   = last_change;
    prev    = sel;
    stray   = 0;
    changed = 1'b0;
    for (int k = 0; k < 3 * DIV && !changed; k++) begin
      if (load_at >= 0 && (cyc - start) == load_at) begin
        carregar = 1'b1;
        valores  = v;
      end
      @(posedge clk);
      #1;
      carregar = 1'b0;
      if (sel !== prev) changed = 1'b1;
      else if (quadro !== 1'b0) stray++;
    end
    check("sel_change_seen", {31'd0, changed}, 32'd1);
    if (!changed) return;
    check("dwell_cycles", cyc - start, DIV);
    check("stray_quadro", stray, 0);
    last_change = cyc;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    $display("digit: sel=%b valor=%h quadro=%b (want sel=%b valor=%h quadro=%b)",
             sel, valor, quadro, e.sel, e.val, e.q);
    check("sel", {28'd0, sel}, {28'd0, e.sel});
    check("valor", {28'd0, valor}, {28'd0, e.val});
    check("quadro", {31'd0, quadro}, {31'd0, e.q});
  endtask

  initial begin
    rst_n       = 1'b0;
    carregar    = 1'b0;
    valores     = 16'h0000;
    apaga_zeros = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("reset: sel=%b valor=%h quadro=%b", sel, valor, quadro);
    check("reset_sel", {28'd0, sel}, 32'h1);
    check("reset_valor", {28'd0, valor}, 32'h0);
    check("reset_quadro", {31'd0, quadro}, 32'h0);

    rst_n = 1'b1;
    last_change = cyc;

    // Frame of zeros; 1234 captured during digit 1 must wait for the boundary.
    push(4'b0010, 4'h0, 1'b0); run_digit(-1, 16'h0);
    push(4'b0100, 4'h0, 1'b0); run_digit(1, 16'h1234);
    push(4'b1000, 4'h0, 1'b0); run_digit(-1, 16'h0);
    push(4'b0001, 4'h4, 1'b1); run_digit(-1, 16'h0);
    push(4'b0010, 4'h3, 1'b0); run_digit(-1, 16'h0);
    push(4'b0100, 4'h2, 1'b0); run_digit(-1, 16'h0);
    push(4'b1000, 4'h1, 1'b0); run_digit(-1, 16'h0);

    // Load coinciding with the 3->0 tick shows up on that frame's digit 0.
    push(4'b0001, 4'h8, 1'b1); run_digit(DIV - 1, 16'h5678);
    push(4'b0010, 4'h7, 1'b0); run_digit(-1, 16'h0);
    push(4'b0100, 4'h6, 1'b0); run_digit(-1, 16'h0);
    apaga_zeros = 1'b1;
    push(4'b1000, 4'h5, 1'b0); run_digit(-1, 16'h0);

    // 0050 captured early in digit 3, copied at the boundary, blanked.
    push(4'b0001, 4'h0, 1'b1); run_digit(0, 16'h0050);
    push(4'b0010, 4'h5, 1'b0); run_digit(-1, 16'h0);
    push(4'b0100, 4'hF, 1'b0); run_digit(2, 16'h0000);
    push(4'b1000, 4'hF, 1'b0); run_digit(-1, 16'h0);

    // All-zero value: F,F,F,0. Two captures before the boundary: last wins.
    push(4'b0001, 4'h0, 1'b1); run_digit(-1, 16'h0);
    push(4'b0010, 4'hF, 1'b0); run_digit(-1, 16'h0);
    push(4'b0100, 4'hF, 1'b0); run_digit(1, 16'h1111);
    push(4'b1000, 4'hF, 1'b0); run_digit(2, 16'hA0B0);

    // A0B0 with blanking on: digit 3 nonzero, nothing blanked.
    push(4'b0001, 4'h0, 1'b1); run_digit(-1, 16'h0);
    push(4'b0010, 4'hB, 1'b0); run_digit(1, 16'h9999);
    push(4'b0100, 4'h0, 1'b0); run_digit(-1, 16'h0);
    push(4'b1000, 4'hA, 1'b0);

    // Reset in the middle of digit 2 with 9999 pending: it must be lost.
    apaga_zeros = 1'b0;
    rst_n = 1'b0;
    #1;
    $display("midscan reset: sel=%b valor=%h quadro=%b", sel, valor, quadro);
    check("midreset_sel", {28'd0, sel}, 32'h1);
    check("midreset_valor", {28'd0, valor}, 32'h0);
    check("midreset_quadro", {31'd0, quadro}, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_change = cyc;
    push(4'b0010, 4'h0, 1'b0); run_digit(-1, 16'h0);
    push(4'b0100, 4'h0, 1'b0); run_digit(-1, 16'h0);
    push(4'b1000, 4'h0, 1'b0); run_digit(-1, 16'h0);
    push(4'b0001, 4'h0, 1'b1); run_digit(-1, 16'h0);
    push(4'b0010, 4'h0, 1'b0); run_digit(-1, 16'h0);

    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
